// File: rtl/conv_pointwise_engine.sv
// Pointwise conv engine: DSP_NO MAC lanes over KERNEL_DIM^2*CHIN taps, bias, shift, saturate.
// Optional ReLU on the quantised outputs when CONV_POINTWISE_RELU_EN is defined.
module conv_pointwise_engine #(
  parameter int DSP_NO     = 112,
  parameter int WIDTH      = 16,
  parameter int CHIN       = 512,
  parameter int KERNEL_DIM = 1,
  parameter int WOUT       = 8,
  parameter int FRAC_SHIFT = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [WIDTH-1:0]          ifm_i,
  input  logic                      ifm_valid_i,
  input  logic [DSP_NO*WIDTH-1:0]   kernels_i,
  input  logic [DSP_NO*2*WIDTH-1:0] bias_i,
  input  logic                      ram_feedback_i,
  output logic                      rom_clr_pulse_o,
  output logic [DSP_NO*WIDTH-1:0]   ofm_o,
  output logic                      ofm_valid_o,
  output logic                      busy_o,
  output logic                      done_o
);
  localparam int TAPS   = KERNEL_DIM * KERNEL_DIM * CHIN;
  localparam int PIXELS = WOUT * WOUT;
  localparam int AW     = 2 * WIDTH + 8;
  localparam int SW     = AW + 1;
  localparam int TW     = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW     = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  localparam logic signed [SW-1:0]    QMAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0]    QMIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] OMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] OMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                   state_q;
  logic [TW-1:0]            tap_cnt_q;
  logic [PW-1:0]            pix_cnt_q;
  logic                     win_done_q;
  logic                     ofm_valid_q;
  logic                     busy_q;
  logic                     done_q;
  logic [DSP_NO*WIDTH-1:0]  ofm_q;
  logic [DSP_NO*WIDTH-1:0]  ofm_d;
  logic signed [AW-1:0]     acc_q [DSP_NO];
  logic signed [2*WIDTH-1:0] prod [DSP_NO];

  logic beat;
  logic last_tap;
  logic last_pix;

  assign beat     = ifm_valid_i && (state_q == ACCUM);
  assign last_tap = (tap_cnt_q == TW'(TAPS - 1));
  assign last_pix = (pix_cnt_q == PW'(PIXELS - 1));

  for (genvar g = 0; g < DSP_NO; g++) begin : g_lane
    logic signed [SW-1:0]    sum;
    logic signed [SW-1:0]    q;
    logic signed [WIDTH-1:0] sat;
    logic signed [WIDTH-1:0] res;

    assign prod[g] = $signed(ifm_i) * $signed(kernels_i[g*WIDTH +: WIDTH]);
    // Bias is sign-extended onto the accumulator's fractional point before scaling.
    assign sum = SW'(acc_q[g]) + SW'($signed(bias_i[g*2*WIDTH +: 2*WIDTH]));
    assign q   = sum >>> FRAC_SHIFT;
    assign sat = (q > QMAX) ? OMAX : (q < QMIN) ? OMIN : q[WIDTH-1:0];
`ifdef CONV_POINTWISE_RELU_EN
    assign res = sat[WIDTH-1] ? '0 : sat;
`else
    assign res = sat;
`endif
    assign ofm_d[g*WIDTH +: WIDTH] = res;
  end

  // A beat on the win_done cycle overwrites acc on the same edge the output stage samples it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DSP_NO; i++) acc_q[i] <= '0;
    end else if (beat) begin
      for (int i = 0; i < DSP_NO; i++)
        acc_q[i] <= (tap_cnt_q == '0) ? AW'(prod[i]) : acc_q[i] + AW'(prod[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tap_cnt_q   <= '0;
      pix_cnt_q   <= '0;
      win_done_q  <= 1'b0;
      ofm_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ofm_q       <= '0;
    end else begin
      win_done_q  <= 1'b0;
      ofm_valid_q <= 1'b0;
      if (beat) begin
        tap_cnt_q  <= last_tap ? '0 : tap_cnt_q + TW'(1);
        win_done_q <= last_tap;
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q   <= ACCUM;
            busy_q    <= 1'b1;
            tap_cnt_q <= '0;
            pix_cnt_q <= '0;
          end
        end
        ACCUM: begin
          if (win_done_q) begin
            ofm_q       <= ofm_d;
            ofm_valid_q <= 1'b1;
            if (last_pix) begin
              pix_cnt_q <= '0;
              state_q   <= DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              pix_cnt_q <= pix_cnt_q + PW'(1);
            end
          end
        end
        DONE: begin
          if (ram_feedback_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_clr_pulse_o = win_done_q;
  assign ofm_o           = ofm_q;
  assign ofm_valid_o     = ofm_valid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_conv_pointwise_engine.sv
// Bench for conv_pointwise_engine: two instances (shift 0 and 14) against an arithmetic window model.
module tb_conv_pointwise_engine;
  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [15:0] ifm_i;
  logic        ifm_valid_i;
  logic [31:0] kernels_i;
  logic [63:0] bias_i;
  logic        ram_feedback_i;

  logic        rc0, ov0, busy0, done0;
  logic [31:0] ofm0;
  logic        rc1, ov1, busy1, done1;
  logic [31:0] ofm1;

  conv_pointwise_engine #(.DSP_NO(2), .WIDTH(16), .CHIN(4), .KERNEL_DIM(1), .WOUT(2), .FRAC_SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .ifm_i(ifm_i), .ifm_valid_i(ifm_valid_i),
    .kernels_i(kernels_i), .bias_i(bias_i), .ram_feedback_i(ram_feedback_i),
    .rom_clr_pulse_o(rc0), .ofm_o(ofm0), .ofm_valid_o(ov0), .busy_o(busy0), .done_o(done0));

  conv_pointwise_engine #(.DSP_NO(2), .WIDTH(16), .CHIN(4), .KERNEL_DIM(1), .WOUT(2), .FRAC_SHIFT(14)) dut14 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .ifm_i(ifm_i), .ifm_valid_i(ifm_valid_i),
    .kernels_i(kernels_i), .bias_i(bias_i), .ram_feedback_i(ram_feedback_i),
    .rom_clr_pulse_o(rc1), .ofm_o(ofm1), .ofm_valid_o(ov1), .busy_o(busy1), .done_o(done1));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int          lb_q [$];
  int          rc_q [$];
  int          sc_q [$];
  logic [31:0] o0_q [$];
  logic [31:0] o1_q [$];
  logic [31:0] exp0_q [$];
  logic [31:0] exp1_q [$];
  logic [31:0] last_e0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rc0) rc_q.push_back(cyc);
    if (ov0) begin
      sc_q.push_back(cyc);
      o0_q.push_back(ofm0);
    end
    if (ov1) o1_q.push_back(ofm1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural quantiser: plain integer arithmetic on the exact window sum.
  function automatic logic [15:0] ref_lane(input longint acc, input longint bias, input int sh);
    longint s;
    longint q;
    s = acc + bias;
    q = s >>> sh;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`ifdef CONV_POINTWISE_RELU_EN
    if (q < 0) q = 0;
`endif
    return q[15:0];
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ifm_valid_i = 1'b0;
    end
  endtask

  task automatic start_layer();
    @(negedge clk);
    ifm_valid_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_after_start", busy0, 1);
  endtask

  // kind: 0 directed ramp, 1 random, 2 saturation, 3 zero activations
  task automatic window(input bit gaps, input int kind);
    longint a0, a1, b0, b1;
    logic signed [15:0] x, k0, k1;
    int lb;
    a0 = 0;
    a1 = 0;
    lb = 0;
    for (int t = 0; t < 4; t++) begin
      case (kind)
        0: begin x = 16'(t + 1); k0 = 16'sd1; k1 = -16'sd1; end
        1: begin x = 16'($urandom); k0 = 16'($urandom); k1 = 16'($urandom); end
        2: begin x = 16'h4000; k0 = 16'h7fff; k1 = 16'h8001; end
        default: begin x = '0; k0 = 16'($urandom); k1 = 16'($urandom); end
      endcase
      @(negedge clk);
      ifm_valid_i = 1'b1;
      ifm_i = x;
      kernels_i = {k1, k0};
      if (t == 3) lb = cyc;
      a0 += longint'(x) * longint'(k0);
      a1 += longint'(x) * longint'(k1);
      if (gaps && t < 3) begin
        @(negedge clk);
        ifm_valid_i = 1'b0;
        ifm_i = 16'($urandom);
        kernels_i = $urandom;
      end
    end
    lb_q.push_back(lb);
    b0 = longint'($signed(bias_i[31:0]));
    b1 = longint'($signed(bias_i[63:32]));
    exp0_q.push_back({ref_lane(a1, b1, 0), ref_lane(a0, b0, 0)});
    exp1_q.push_back({ref_lane(a1, b1, 14), ref_lane(a0, b0, 14)});
  endtask

  task automatic check_window(input string tag);
    int L;
    logic [31:0] e0, e1;
    L  = lb_q.pop_front();
    e0 = exp0_q.pop_front();
    e1 = exp1_q.pop_front();
    last_e0 = e0;
    for (int k = 0; k < 30 && (sc_q.size() == 0 || o1_q.size() == 0 || rc_q.size() == 0); k++)
      @(negedge clk);
    check({tag, "_strobe_seen"}, (sc_q.size() > 0 && o1_q.size() > 0 && rc_q.size() > 0), 1);
    if (sc_q.size() == 0 || o1_q.size() == 0 || rc_q.size() == 0) return;
    check({tag, "_romclr_cycle"}, rc_q.pop_front(), L + 1);
    check({tag, "_strobe_cycle"}, sc_q.pop_front(), L + 2);
    check({tag, "_ofm_shift0"}, o0_q.pop_front(), e0);
    check({tag, "_ofm_shift14"}, o1_q.pop_front(), e1);
  endtask

  initial begin
    int s_prev;
    int s_cur;
    rst_n = 1'b0;
    start_i = 1'b0;
    ifm_i = '0;
    ifm_valid_i = 1'b0;
    kernels_i = '0;
    bias_i = '0;
    ram_feedback_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ofm0", ofm0, 0);
    check("rst_ofm1", ofm1, 0);
    check("rst_valid", ov0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_romclr", rc0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Beats while idle must not disturb the first window.
    repeat (3) begin
      @(negedge clk);
      ifm_valid_i = 1'b1;
      ifm_i = 16'($urandom);
      kernels_i = $urandom;
    end
    idle(1);
    check("idle_no_romclr", rc_q.size(), 0);

    start_layer();
    window(0, 0);
    idle(4);
    check_window("ramp");
    window(1, 0);
    idle(4);
    check_window("ramp_gapped");
    bias_i = {32'(-(3 <<< 14)), 32'(5 <<< 14)};
    window(0, 3);
    idle(4);
    check_window("bias");
    bias_i = '0;
    window(0, 2);
    idle(4);
    check_window("saturate");
    check("layer1_done", done0, 1);
    check("layer1_not_busy", busy0, 0);
    repeat (4) begin
      @(negedge clk);
      ifm_valid_i = 1'b1;
      ifm_i = 16'($urandom);
      kernels_i = $urandom;
    end
    idle(4);
    check("done_ignores_beats", sc_q.size() + rc_q.size(), 0);
    check("ofm_holds", ofm0, last_e0);
    check("done_held", done0, 1);
    @(negedge clk);
    ram_feedback_i = 1'b1;
    @(negedge clk);
    ram_feedback_i = 1'b0;
    check("feedback_clears_done", done0, 0);

    // Back-to-back windows with a fixed random bias.
    bias_i = {32'($urandom), 32'($urandom)};
    start_layer();
    for (int w = 0; w < 4; w++) window(0, 1);
    idle(6);
    s_prev = 0;
    for (int w = 0; w < 4; w++) begin
      if (sc_q.size() > 0) s_cur = sc_q[0];
      else s_cur = s_prev + 4;
      if (w > 0) check("b2b_spacing", s_cur - s_prev, 4);
      s_prev = s_cur;
      check_window("b2b");
    end
    check("layer2_done", done0, 1);
    @(negedge clk);
    ram_feedback_i = 1'b1;
    @(negedge clk);
    ram_feedback_i = 1'b0;

    // Abort mid-window, then a clean window after restart.
    bias_i = {32'($urandom), 32'($urandom)};
    start_layer();
    repeat (3) begin
      @(negedge clk);
      ifm_valid_i = 1'b1;
      ifm_i = 16'($urandom);
      kernels_i = $urandom;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_ofm0", ofm0, 0);
    check("abort_ofm1", ofm1, 0);
    check("abort_busy", busy0, 0);
    check("abort_valid", ov0, 0);
    check("abort_romclr", rc0, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    check("abort_no_strobe", sc_q.size() + rc_q.size(), 0);
    start_layer();
    window(0, 1);
    idle(4);
    check_window("post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
